// File: rtl/cam_pkg.sv
// Shared types and constants for the camera pixel-capture stage.
package cam_pkg;

    typedef enum logic [1:0] {
        S_SYNC  = 2'd0,
        S_FRAME = 2'd1,
        S_BYTE1 = 2'd2
    } cam_state_e;

    localparam int H_ACTIVE_DEF = 640;
    localparam int V_ACTIVE_DEF = 480;
    localparam int PIX_W        = 12;
    localparam int FRAME_CNT_W  = 16;
    localparam int POS_W        = 10;

    // Saturating increment for the x/y position counters.
    function automatic logic [POS_W-1:0] sat_inc(input logic [POS_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/cam_edge_det.sv
// Registers one camera sync line and flags its rising/falling edges
// by comparing the current sample with the previous one.
module cam_edge_det (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_sig,
    output logic o_rise,
    output logic o_fall
);

    logic sig_q;

    // Previous-sample register.
    always_ff @(posedge i_clk) begin
        if (i_rst) sig_q <= 1'b0;
        else       sig_q <= i_sig;
    end

    assign o_rise = i_sig & ~sig_q;
    assign o_fall = ~i_sig & sig_q;

endmodule

// File: rtl/cam_capture.sv
// Camera capture: samples VSYNC/HREF/data, packs two RGB444 bytes into a
// 12-bit pixel, writes the FIFO and checks line/frame geometry.
// FIFO handshake: o_wr is a one-cycle push strobe; when i_full is high at the
// byte1 sample the pixel is dropped (no back-pressure to the camera).
module cam_capture
    import cam_pkg::*;
#(
    parameter int H_ACTIVE = H_ACTIVE_DEF,
    parameter int V_ACTIVE = V_ACTIVE_DEF
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_en,
    input  logic                   i_vsync,
    input  logic                   i_href,
    input  logic [7:0]             i_data,
    output logic                   o_wr,
    output logic [PIX_W-1:0]       o_wdata,
    input  logic                   i_full,
    output logic                   o_sof,
    output logic                   o_frame_done,
    output logic [FRAME_CNT_W-1:0] o_frame_cnt,
    output logic                   o_overflow,
    output logic                   o_line_err,
    output logic                   o_frame_err,
    input  logic                   i_clr_err
);

    localparam logic [POS_W-1:0] H_L = POS_W'(H_ACTIVE);
    localparam logic [POS_W-1:0] V_L = POS_W'(V_ACTIVE);

    logic vs_rise, vs_fall, hr_fall, hr_rise_unused;

    cam_edge_det u_vs_edge (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_sig (i_vsync),
        .o_rise(vs_rise),
        .o_fall(vs_fall)
    );

    cam_edge_det u_hr_edge (
        .i_clk (i_clk),
        .i_rst (i_rst),
        .i_sig (i_href),
        .o_rise(hr_rise_unused),
        .o_fall(hr_fall)
    );

    cam_state_e             state_q, state_d;
    logic [POS_W-1:0]       x_q, x_d, y_q, y_d, y_line;
    logic [3:0]             byte0_q, byte0_d;
    logic                   wr_q, wr_d, sof_q, sof_d, done_q, done_d;
    logic                   sof_pend_q, sof_pend_d;
    logic [PIX_W-1:0]       wdata_q, wdata_d;
    logic [FRAME_CNT_W-1:0] cnt_q, cnt_d;
    logic                   ovf_q, ovf_d, line_q, line_d, frame_q, frame_d;
    logic                   ovf_set, line_set, frame_set;

    // Next-state: FSM, byte packer, position counters and error detection.
    always_comb begin
        state_d    = state_q;
        x_d        = x_q;
        y_d        = y_q;
        y_line     = y_q;
        byte0_d    = byte0_q;
        wr_d       = 1'b0;
        wdata_d    = wdata_q;
        sof_d      = 1'b0;
        done_d     = 1'b0;
        cnt_d      = cnt_q;
        sof_pend_d = sof_pend_q;
        ovf_set    = 1'b0;
        line_set   = 1'b0;
        frame_set  = 1'b0;
        case (state_q)
            S_SYNC: begin
                // Only a full frame is ever captured: wait for blanking to end.
                if (vs_fall && i_en) begin
                    state_d    = S_FRAME;
                    x_d        = '0;
                    y_d        = '0;
                    sof_pend_d = 1'b1;
                end
            end
            S_FRAME, S_BYTE1: begin
                // Line end is evaluated before a coincident frame end.
                if (hr_fall) begin
                    if (x_q != H_L) line_set = 1'b1;
                    y_line = sat_inc(y_q);
                    x_d    = '0;
                end
                // HREF dropped with byte0 pending: odd byte count.
                if (state_q == S_BYTE1 && !i_href) line_set = 1'b1;
                if (vs_rise) begin
                    // HREF still high here means the line was cut short.
                    if (i_href) line_set = 1'b1;
                    if (y_line != V_L) frame_set = 1'b1;
                    done_d     = 1'b1;
                    cnt_d      = cnt_q + 1'b1;
                    x_d        = '0;
                    y_d        = '0;
                    sof_pend_d = 1'b0;
                    state_d    = S_SYNC;
                end else begin
                    y_d = y_line;
                    if (state_q == S_FRAME) begin
                        if (i_href) begin
                            byte0_d = i_data[3:0];
                            state_d = S_BYTE1;
                        end
                    end else if (i_href) begin
                        x_d     = sat_inc(x_q);
                        state_d = S_FRAME;
                        if (i_full) begin
                            ovf_set = 1'b1;
                        end else begin
                            wr_d    = 1'b1;
                            wdata_d = {byte0_q, i_data};
                            if (sof_pend_q) begin
                                sof_d      = 1'b1;
                                sof_pend_d = 1'b0;
                            end
                        end
                    end else begin
                        state_d = S_FRAME;
                    end
                end
            end
            default: state_d = S_SYNC;
        endcase
        // A new error in the same cycle as a clear keeps the flag set.
        ovf_d   = (ovf_q   & ~i_clr_err) | ovf_set;
        line_d  = (line_q  & ~i_clr_err) | line_set;
        frame_d = (frame_q & ~i_clr_err) | frame_set;
    end

    // State and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q    <= S_SYNC;
            x_q        <= '0;
            y_q        <= '0;
            byte0_q    <= '0;
            wr_q       <= 1'b0;
            wdata_q    <= '0;
            sof_q      <= 1'b0;
            done_q     <= 1'b0;
            cnt_q      <= '0;
            sof_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
            line_q     <= 1'b0;
            frame_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            x_q        <= x_d;
            y_q        <= y_d;
            byte0_q    <= byte0_d;
            wr_q       <= wr_d;
            wdata_q    <= wdata_d;
            sof_q      <= sof_d;
            done_q     <= done_d;
            cnt_q      <= cnt_d;
            sof_pend_q <= sof_pend_d;
            ovf_q      <= ovf_d;
            line_q     <= line_d;
            frame_q    <= frame_d;
        end
    end

    assign o_wr         = wr_q;
    assign o_wdata      = wdata_q;
    assign o_sof        = sof_q;
    assign o_frame_done = done_q;
    assign o_frame_cnt  = cnt_q;
    assign o_overflow   = ovf_q;
    assign o_line_err   = line_q;
    assign o_frame_err  = frame_q;

endmodule

// File: tb/tb_cam_capture.sv
// Directed/randomized bench for cam_capture with a small frame geometry.
module tb_cam_capture;

    localparam int H = 8;
    localparam int V = 4;

    logic        clk = 1'b0;
    logic        rst, en, vsync, href, full, clr;
    logic [7:0]  data;
    logic        o_wr, o_sof, o_frame_done, o_overflow, o_line_err, o_frame_err;
    logic [11:0] o_wdata;
    logic [15:0] o_frame_cnt;

    always #5 clk = ~clk;

    cam_capture #(.H_ACTIVE(H), .V_ACTIVE(V)) dut (
        .i_clk(clk), .i_rst(rst), .i_en(en), .i_vsync(vsync), .i_href(href),
        .i_data(data), .o_wr(o_wr), .o_wdata(o_wdata), .i_full(full),
        .o_sof(o_sof), .o_frame_done(o_frame_done), .o_frame_cnt(o_frame_cnt),
        .o_overflow(o_overflow), .o_line_err(o_line_err),
        .o_frame_err(o_frame_err), .i_clr_err(clr)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // Expected writes: {sof, cycle[31:0], pixel[11:0]}
    logic [44:0] exp_q[$];
    logic [44:0] mon_e;

    // Reference model state
    bit capturing, sof_pend, href_now, force_abc;
    bit e_ovf, e_line, e_frame;
    int lines, exp_cnt, exp_done, exp_wr;

    // Monitor observations
    int done_seen = 0;
    int wr_seen   = 0;
    logic [11:0] sof_data = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // Write scoreboard, sampled on the falling edge.
    always @(negedge clk) begin
        if (o_frame_done === 1'b1) done_seen++;
        if (o_wr === 1'b1) begin
            wr_seen++;
            if (o_sof === 1'b1) sof_data = o_wdata;
            if (exp_q.size() == 0) begin
                chk("unexpected_wr", 32'(o_wr), 32'd0);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wdata", 32'(o_wdata), 32'(mon_e[11:0]));
                chk("wr_cycle", 32'(cyc), mon_e[43:12]);
                chk("sof", 32'(o_sof), 32'(mon_e[44]));
            end
        end else begin
            if (o_sof === 1'b1) chk("sof_without_wr", 32'(o_sof), 32'd0);
            while (exp_q.size() > 0 && exp_q[0][43:12] < 32'(cyc)) begin
                mon_e = exp_q.pop_front();
                chk("missing_wr", 32'(o_wr), 32'd1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_pix(input logic [7:0] b0, input logic [7:0] b1);
        logic [11:0] v;
        v = {b0[3:0], b1};
        exp_q.push_back({sof_pend, 32'(cyc + 1), v});
        sof_pend = 1'b0;
        exp_wr++;
    endtask

    task automatic model_rise();
        if (capturing) begin
            exp_done++;
            exp_cnt = (exp_cnt + 1) & 32'hFFFF;
            if (lines != V) e_frame = 1'b1;
            if (href_now) e_line = 1'b1;
        end
        capturing = 1'b0;
        sof_pend  = 1'b0;
    endtask

    // Drive n line bytes; leaves HREF high. fmask bit k holds i_full for pixel k.
    task automatic send_bytes(input int n, input logic [15:0] fmask);
        logic [7:0] b0;
        b0 = '0;
        for (int i = 0; i < n; i++) begin
            tick();
            href = 1'b1;
            href_now = 1'b1;
            data = 8'($urandom_range(0, 255));
            if (force_abc && i < 2) data = (i == 0) ? 8'h0A : 8'hBC;
            full = (i % 2 == 1) ? fmask[i / 2] : 1'b0;
            if (i % 2 == 0) b0 = data;
            else if (capturing) begin
                if (full) e_ovf = 1'b1;
                else push_pix(b0, data);
            end
        end
    endtask

    task automatic send_line(input int n, input logic [15:0] fmask, input bit vs_at_end, input bit clr_at_end);
        send_bytes(n, fmask);
        tick();
        href = 1'b0;
        href_now = 1'b0;
        full = 1'b0;
        if (clr_at_end) begin
            clr = 1'b1;
            e_ovf = 1'b0; e_line = 1'b0; e_frame = 1'b0;
        end
        if (capturing) begin
            lines++;
            if (n != 2 * H) e_line = 1'b1;
        end
        if (vs_at_end) begin
            vsync = 1'b1;
            model_rise();
        end
        tick();
        clr = 1'b0;
        tick();
    endtask

    task automatic vs_rise();
        tick();
        vsync = 1'b1;
        if (href_now) data = 8'($urandom_range(0, 255));
        model_rise();
        tick();
        href = 1'b0;
        href_now = 1'b0;
        tick();
    endtask

    task automatic vs_fall(input bit en_v);
        en = en_v;
        repeat (3) tick();
        vsync = 1'b0;
        capturing = en_v;
        sof_pend = en_v;
        lines = 0;
        repeat (3) tick();
    endtask

    task automatic clr_pulse();
        tick();
        clr = 1'b1;
        e_ovf = 1'b0; e_line = 1'b0; e_frame = 1'b0;
        tick();
        clr = 1'b0;
    endtask

    task automatic do_reset();
        tick();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
        capturing = 1'b0; sof_pend = 1'b0; lines = 0;
        e_ovf = 1'b0; e_line = 1'b0; e_frame = 1'b0;
        exp_cnt = 0;
    endtask

    task automatic checkpoint(input string tag);
        @(negedge clk);
        chk({tag, ":frame_cnt"}, 32'(o_frame_cnt), 32'(exp_cnt));
        chk({tag, ":done_cnt"}, 32'(done_seen), 32'(exp_done));
        chk({tag, ":wr_cnt"}, 32'(wr_seen), 32'(exp_wr));
        chk({tag, ":overflow"}, 32'(o_overflow), 32'(e_ovf));
        chk({tag, ":line_err"}, 32'(o_line_err), 32'(e_line));
        chk({tag, ":frame_err"}, 32'(o_frame_err), 32'(e_frame));
    endtask

    initial begin
        rst = 1'b1; en = 1'b1; vsync = 1'b0; href = 1'b0; data = '0;
        full = 1'b0; clr = 1'b0;
        capturing = 1'b0; sof_pend = 1'b0; href_now = 1'b0; force_abc = 1'b0;
        e_ovf = 1'b0; e_line = 1'b0; e_frame = 1'b0;
        lines = 0; exp_cnt = 0; exp_done = 0; exp_wr = 0;

        // Reset values
        do_reset();
        @(negedge clk);
        chk("rst:o_wr", 32'(o_wr), 32'd0);
        chk("rst:o_wdata", 32'(o_wdata), 32'd0);
        chk("rst:o_sof", 32'(o_sof), 32'd0);
        chk("rst:o_frame_done", 32'(o_frame_done), 32'd0);
        chk("rst:o_frame_cnt", 32'(o_frame_cnt), 32'd0);
        chk("rst:o_overflow", 32'(o_overflow), 32'd0);
        chk("rst:o_line_err", 32'(o_line_err), 32'd0);
        chk("rst:o_frame_err", 32'(o_frame_err), 32'd0);

        // Stream already running after reset: nothing captured yet
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        checkpoint("midstart");
        vs_rise();
        vs_fall(1'b1);

        // Clean full frame, first pixel 0xABC
        force_abc = 1'b1;
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        force_abc = 1'b0;
        repeat (V - 1) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("clean");
        chk("first_pixel", 32'(sof_data), 32'h0ABC);
        vs_fall(1'b1);

        // FIFO full for pixels 2..4 of line 0
        send_line(2 * H, 16'h001C, 1'b0, 1'b0);
        repeat (V - 1) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("full");
        clr_pulse();
        checkpoint("full_clr");
        vs_fall(1'b1);

        // Random full pattern; last HREF fall coincides with VSYNC rise
        for (int l = 0; l < V; l++)
            send_line(2 * H, 16'($urandom), (l == V - 1), 1'b0);
        checkpoint("rand");
        clr_pulse();
        vs_fall(1'b1);

        // Odd-length line and short frame
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        send_line(2 * H - 1, 16'h0, 1'b0, 1'b0);
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("odd_short");
        clr_pulse();
        vs_fall(1'b1);

        // Clear coincident with a new line error
        send_line(2 * H - 1, 16'h0, 1'b0, 1'b1);
        checkpoint("clr_race");
        repeat (V - 1) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("clr_race_end");
        clr_pulse();
        vs_fall(1'b1);

        // VSYNC rises mid-line with a pixel half-assembled
        repeat (2) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        send_bytes(11, 16'h0);
        vs_rise();
        checkpoint("abort");
        clr_pulse();
        vs_fall(1'b1);
        repeat (V) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("after_abort");
        vs_fall(1'b1);

        // Reset mid-line, then enable low at the next frame start
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        send_bytes(7, 16'h0);
        do_reset();
        checkpoint("mid_rst");
        send_line(9, 16'h0, 1'b0, 1'b0);
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        vs_fall(1'b0);
        repeat (V) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("en_low");

        // Enable dropped mid-frame: current frame still completes
        vs_fall(1'b1);
        send_line(2 * H, 16'h0, 1'b0, 1'b0);
        en = 1'b0;
        repeat (V - 1) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        vs_fall(1'b0);
        repeat (2) send_line(2 * H, 16'h0, 1'b0, 1'b0);
        vs_rise();
        checkpoint("en_mid");

        repeat (3) tick();
        chk("exp_q_drained", 32'(exp_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
